// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one ripple-carry partial add per clock.
// Optional two's-complement operands when MULT_SIGNED_EN is defined.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             last;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic [WIDTH-1:0] ld_mcand;
  logic [WIDTH-1:0] ld_mplier;
  logic [2*WIDTH-1:0] res;
  logic [2*WIDTH-1:0] res_out;

  // acc MSB is always zero after a shift; the carry lands one bit lower
  logic unused_acc_msb;
  assign unused_acc_msb = acc[WIDTH];

  assign addend = mplier[0] ? mcand : '0;
  assign c[0]   = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder u_fa (
      .a    (acc[i]),
      .b    (addend[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign acc_nxt    = {c[WIDTH], sum[WIDTH-1:1]};
  assign mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
  assign res        = {acc_nxt, mplier_nxt};
  assign last       = (cnt == CW'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
  logic neg;
  assign ld_mcand  = a[WIDTH-1] ? -a : a;
  assign ld_mplier = b[WIDTH-1] ? -b : b;
  assign res_out   = neg ? -res : res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (state == IDLE && start) begin
      neg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign ld_mcand  = a;
  assign ld_mplier = b;
  assign res_out   = res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (state == IDLE && start) begin
        mcand  <= ld_mcand;
        mplier <= ld_mplier;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        acc    <= {1'b0, acc_nxt};
        mplier <= mplier_nxt;
        cnt    <= cnt + CW'(1);
        if (last) product <= res_out;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule
